mc_controller: RTL and testbench
================================

# mc_controller

Parametrised multicycle control FSM for the MIPS-subset datapath. It sequences fetch, decode, execute, memory and writeback for each instruction and drives every datapath enable and mux select. Compared with the fixed 8-bit controller it adds a configurable number of instruction-fetch beats, a memory-ready stall handshake, `addi`, an illegal-instruction flag and optional `bne`. It sits between the instruction register opcode/funct fields and the datapath control inputs.

## Interface
- `FETCH_BEATS`, 4: memory beats per instruction fetch (1..4). Sets the `irwrite` width and the PC increment beats.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 6: opcode field of the instruction register.
- `funct` in 6: funct field of the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: the memory completes the current read or write this cycle.
- `memread`, `memwrite`, `alusrca`, `memtoreg`, `iord`, `regwrite`, `regdst` out 1: datapath controls.
- `pcen` out 1: PC write enable.
- `pcsrc` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `alusrcb` out 2: 00 reg B, 01 constant 1, 10 sign-extended immediate, 11 shifted immediate.
- `aluCtrl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `irwrite` out FETCH_BEATS: one-hot IR byte-lane write enable.
- `illegal` out 1: one-cycle pulse on an unsupported op or funct.

## Operation
- States (in the package): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, JEX, ADDIEX, ADDIWB, plus BNEEX when the macro is set.
- Beat counter `beat` runs 0..FETCH_BEATS-1 and is valid in FETCH only.
- FETCH outputs:
  - memread=1, alusrca=0, alusrcb=01, aluCtrl=add, pcsrc=00.
  - When mem_ready=1: irwrite[beat]=1 and pcwrite=1.
  - When mem_ready=0: state and beat hold, irwrite=0, pcwrite=0.
  - On the last beat with mem_ready=1, go to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluCtrl=add. Branch target goes to ALUOut. Dispatch on `op`:
  - 0x23 or 0x2B -> MEMADR
  - 0x00 -> RTYPEEX
  - 0x04 -> BEQEX
  - 0x02 -> JEX
  - 0x08 -> ADDIEX
  - 0x05 -> BNEEX (macro only)
  - anything else -> FETCH, with illegal=1 in the DECODE cycle.
- MEMADR: alusrca=1, alusrcb=10, add. Next is MEMRD for 0x23 and MEMWR for 0x2B.
- MEMRD: iord=1, memread=1. Holds until mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Next is FETCH.
- MEMWR: iord=1, memwrite=1. Holds until mem_ready, then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluCtrl from the funct decode.
  - funct map: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Any other funct: illegal=1 and aluCtrl=add. The FSM still proceeds.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1.
- BNEEX: same as BEQEX with nbranch=1.
- JEX: pcsrc=10, pcwrite=1.
- ADDIEX: alusrca=1, alusrcb=10, add.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0.
- BEQEX, BNEEX and JEX return to FETCH with beat=0.
- Output encoding: pcen = pcwrite | (branch & zero) | (nbranch & ~zero).
- Unlisted outputs are 0 in every state.

## Timing
- All outputs are combinational decodes of state, beat, op, funct, zero and mem_ready. State updates on the rising clk edge.
- Reset: state=FETCH, beat=0. While reset is high, pcen, irwrite, regwrite, memwrite and illegal are forced to 0. The other outputs show FETCH values.
- Reset asserted mid-instruction aborts it. The first fetch beat starts on the first edge after reset deasserts.
- Cycle counts with zero wait states (F = FETCH_BEATS):
  - lw: F+4
  - sw, R-type, addi: F+3
  - beq, bne, j: F+2
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in all other states.

## Configuration
- Macro `MC_BNE_EN`.
- Defined: BNEEX exists and op 0x05 dispatches to it. The PC is loaded from ALUOut when zero=0.
- Undefined: op 0x05 is illegal, meaning an illegal pulse in DECODE and a return to FETCH.

## Structure
- Package `mc_ctrl_pkg`:
  - state enum
  - opcode constants: LW, SW, RTYPE, BEQ, BNE, J, ADDI
  - funct constants
  - ALU control codes
  - 2-bit aluop: 00 add, 01 sub, 10 funct
- Sub-module `mc_alu_decoder`: combinational. Inputs aluop and funct; outputs aluCtrl and bad_funct.

## Test plan
- Reset, FETCH_BEATS=4, mem_ready=1, op=0x00, funct=0x20:
  - irwrite steps 0001, 0010, 0100, 1000 with pcen=1 on each beat.
  - Then DECODE, then RTYPEEX with aluCtrl=010, then RTYPEWB with regwrite=1 and regdst=1.
- lw (op=0x23), mem_ready held low for 3 cycles in MEMRD: memread=1 and iord=1 held for 4 cycles. MEMWB follows with memtoreg=1 and regwrite=1. Total is 11 cycles.
- beq (op=0x04):
  - zero=1: pcen=1 and pcsrc=01 in BEQEX.
  - zero=0: pcen=0.
  - Both cases then return to FETCH beat 0.
- Undefined op 0x3F in DECODE: illegal=1 for one cycle, then FETCH. op=0x05 is illegal without `MC_BNE_EN`; with it, zero=0 gives pcen=1.
- Reset pulsed during MEMWR: memwrite drops asynchronously and the FSM restarts at FETCH beat 0. With FETCH_BEATS=1, irwrite=1 and the next state is DECODE.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle MIPS-subset controller.
// Contents: FSM state enum, opcode/funct constants, ALU control codes, the 2-bit
// aluop encoding and an opcode-legality helper.
// Build option: define MC_BNE_EN to add the BNEEX state and make op 0x05 legal.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPEEX,
        RTYPEWB,
        BEQEX,
        JEX,
        ADDIEX,
        ADDIWB
`ifdef MC_BNE_EN
        , BNEEX
`endif
    } state_t;

    // Opcodes
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;
    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] BNE   = 6'h05;
    localparam logic [5:0] J     = 6'h02;
    localparam logic [5:0] ADDI  = 6'h08;

    // R-type funct codes
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOP_NONE is used by states that do not drive the ALU; it yields aluCtrl=000.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } aluop_t;

    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        ok = (op == LW) || (op == SW) || (op == RTYPE) || (op == BEQ) ||
             (op == J) || (op == ADDI);
`ifdef MC_BNE_EN
        ok = ok || (op == BNE);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: combinational ALU control decode.
// Ports:
//   aluop     in  2 : 00 add, 01 sub, 10 decode funct, 11 no ALU use (000)
//   funct     in  6 : R-type funct field
//   aluCtrl   out 3 : ALU operation code
//   bad_funct out 1 : funct not supported (only when aluop selects funct)
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  aluCtrl,
    output logic        bad_funct
);

    always_comb begin
        aluCtrl   = ALU_ADD;
        bad_funct = 1'b0;
        case (aluop)
            ALUOP_ADD: aluCtrl = ALU_ADD;
            ALUOP_SUB: aluCtrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   aluCtrl = ALU_ADD;
                    F_SUB:   aluCtrl = ALU_SUB;
                    F_AND:   aluCtrl = ALU_AND;
                    F_OR:    aluCtrl = ALU_OR;
                    F_SLT:   aluCtrl = ALU_SLT;
                    default: begin
                        aluCtrl   = ALU_ADD;
                        bad_funct = 1'b1;
                    end
                endcase
            end
            default: aluCtrl = 3'b000;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for the MIPS-subset datapath.
// Parameter FETCH_BEATS (1..4): memory beats per instruction fetch.
// Ports:
//   clk, reset (async, active-high)
//   op, funct        : instruction register fields
//   zero             : ALU zero flag
//   mem_ready        : memory completes the current access this cycle
//   memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen : controls
//   pcsrc[1:0], alusrcb[1:0], aluCtrl[2:0] : mux selects / ALU op
//   irwrite[FETCH_BEATS-1:0] : one-hot IR byte-lane write enable
//   illegal          : pulse on unsupported op (DECODE) or funct (RTYPEEX)
// Build option: define MC_BNE_EN to support bne (op 0x05).
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned FETCH_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op,
    input  logic [5:0]             funct,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   memread,
    output logic                   memwrite,
    output logic                   alusrca,
    output logic                   memtoreg,
    output logic                   iord,
    output logic                   regwrite,
    output logic                   regdst,
    output logic                   pcen,
    output logic [1:0]             pcsrc,
    output logic [1:0]             alusrcb,
    output logic [2:0]             aluCtrl,
    output logic [FETCH_BEATS-1:0] irwrite,
    output logic                   illegal
);

    localparam int unsigned BW = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(FETCH_BEATS - 1);

    state_t        state;
    logic [BW-1:0] beat;

    aluop_t aluop;
    logic   pcwrite, branch, nbranch, bad_op, bad_funct, fetch_fire;
    logic   regwrite_int, memwrite_int;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            beat  <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        if (beat == LAST_BEAT) begin
                            state <= DECODE;
                            beat  <= '0;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DECODE: begin
                    case (op)
                        LW, SW:  state <= MEMADR;
                        RTYPE:   state <= RTYPEEX;
                        BEQ:     state <= BEQEX;
                        J:       state <= JEX;
                        ADDI:    state <= ADDIEX;
`ifdef MC_BNE_EN
                        BNE:     state <= BNEEX;
`endif
                        default: state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (op == SW) ? MEMWR : MEMRD;
                MEMRD:   if (mem_ready) state <= MEMWB;
                MEMWB:   state <= FETCH;
                MEMWR:   if (mem_ready) state <= FETCH;
                RTYPEEX: state <= RTYPEWB;
                ADDIEX:  state <= ADDIWB;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        memread      = 1'b0;
        memwrite_int = 1'b0;
        alusrca      = 1'b0;
        memtoreg     = 1'b0;
        iord         = 1'b0;
        regwrite_int = 1'b0;
        regdst       = 1'b0;
        pcsrc        = 2'b00;
        alusrcb      = 2'b00;
        aluop        = ALUOP_NONE;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        nbranch      = 1'b0;
        bad_op       = 1'b0;
        fetch_fire   = 1'b0;
        case (state)
            FETCH: begin
                memread    = 1'b1;
                alusrcb    = 2'b01;
                aluop      = ALUOP_ADD;
                fetch_fire = mem_ready;
                pcwrite    = mem_ready;
            end
            DECODE: begin
                alusrcb = 2'b11;
                aluop   = ALUOP_ADD;
                bad_op  = !op_legal(op);
            end
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            MEMWB: begin
                regwrite_int = 1'b1;
                memtoreg     = 1'b1;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite_int = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                regwrite_int = 1'b1;
                regdst       = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
`ifdef MC_BNE_EN
            BNEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                nbranch = 1'b1;
            end
`endif
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            ADDIWB: regwrite_int = 1'b1;
            default: ;
        endcase
    end

    mc_alu_decoder u_alu_decoder (
        .aluop     (aluop),
        .funct     (funct),
        .aluCtrl   (aluCtrl),
        .bad_funct (bad_funct)
    );

    // Write-type strobes are suppressed while reset is held; the rest show FETCH values.
    always_comb begin
        for (int i = 0; i < FETCH_BEATS; i++) begin
            irwrite[i] = fetch_fire && !reset && (beat == BW'(i));
        end
    end

    assign pcen     = !reset && (pcwrite || (branch && zero) || (nbranch && !zero));
    assign regwrite = regwrite_int && !reset;
    assign memwrite = memwrite_int && !reset;
    assign illegal  = (bad_op || bad_funct) && !reset;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: a FETCH_BEATS=4 instance and a FETCH_BEATS=1 instance
// checked every cycle against a step-index model, plus directed literal checks.
module tb_mc_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0, reset1;
    logic [5:0] op, funct;
    logic       zero, mem_ready;

    logic       memread0, memwrite0, alusrca0, memtoreg0, iord0, regwrite0, regdst0, pcen0;
    logic [1:0] pcsrc0, alusrcb0;
    logic [2:0] aluctrl0;
    logic [3:0] irwrite0;
    logic       illegal0;

    logic       memread1, memwrite1, alusrca1, memtoreg1, iord1, regwrite1, regdst1, pcen1;
    logic [1:0] pcsrc1, alusrcb1;
    logic [2:0] aluctrl1;
    logic [0:0] irwrite1;
    logic       illegal1;

    mc_controller #(.FETCH_BEATS(4)) u_dut0 (
        .clk(clk), .reset(reset0), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .memread(memread0), .memwrite(memwrite0),
        .alusrca(alusrca0), .memtoreg(memtoreg0), .iord(iord0), .regwrite(regwrite0),
        .regdst(regdst0), .pcen(pcen0), .pcsrc(pcsrc0), .alusrcb(alusrcb0),
        .aluCtrl(aluctrl0), .irwrite(irwrite0), .illegal(illegal0)
    );

    mc_controller #(.FETCH_BEATS(1)) u_dut1 (
        .clk(clk), .reset(reset1), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .memread(memread1), .memwrite(memwrite1),
        .alusrca(alusrca1), .memtoreg(memtoreg1), .iord(iord1), .regwrite(regwrite1),
        .regdst(regdst1), .pcen(pcen1), .pcsrc(pcsrc1), .alusrcb(alusrcb1),
        .aluCtrl(aluctrl1), .irwrite(irwrite1), .illegal(illegal1)
    );

    logic [19:0] v0, v1;
    assign v0 = {irwrite0, memread0, memwrite0, alusrca0, memtoreg0, iord0, regwrite0,
                 regdst0, pcen0, pcsrc0, alusrcb0, aluctrl0, illegal0};
    assign v1 = {3'b000, irwrite1, memread1, memwrite1, alusrca1, memtoreg1, iord1,
                 regwrite1, regdst1, pcen1, pcsrc1, alusrcb1, aluctrl1, illegal1};

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // k = cycle index within the instruction: 0..f-1 fetch beats, f decode, then exec steps.
    // cls: 0 illegal, 1 lw, 2 sw, 3 rtype, 4 beq, 5 j, 6 addi, 7 bne
    function automatic int op_class(input logic [5:0] o);
        case (o)
            6'h23: return 1;
            6'h2B: return 2;
            6'h00: return 3;
            6'h04: return 4;
            6'h02: return 5;
            6'h08: return 6;
`ifdef MC_BNE_EN
            6'h05: return 7;
`endif
            default: return 0;
        endcase
    endfunction

    function automatic int inst_len(input int cls);
        case (cls)
            1: return 3;
            2, 3, 6: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h2A: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic funct_ok(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
    endfunction

    function automatic logic [19:0] model_out(input int f, input int k, input int cls,
                                              input logic rst, input logic [5:0] o,
                                              input logic [5:0] fn, input logic z,
                                              input logic mr);
        logic [3:0] irw;
        logic mrd, mwr, asa, m2r, io, rw, rd, pce, ill;
        logic [1:0] ps, asb;
        logic [2:0] alu;
        int s;
        irw = '0; mrd = 0; mwr = 0; asa = 0; m2r = 0; io = 0; rw = 0; rd = 0; pce = 0;
        ill = 0; ps = 0; asb = 0; alu = 0;
        if (k < f) begin
            mrd = 1; asb = 2'b01; alu = 3'b010;
            if (mr) begin irw = 4'(1 << k); pce = 1; end
        end else begin
            s = k - f;
            if (s == 0) begin
                asb = 2'b11; alu = 3'b010; ill = (op_class(o) == 0);
            end else begin
                case (cls)
                    1, 2: begin
                        if (s == 1) begin asa = 1; asb = 2'b10; alu = 3'b010; end
                        else if (s == 2) begin
                            io = 1;
                            if (cls == 1) mrd = 1; else mwr = 1;
                        end else begin rw = 1; m2r = 1; end
                    end
                    3: begin
                        if (s == 1) begin asa = 1; alu = funct_alu(fn); ill = !funct_ok(fn); end
                        else begin rw = 1; rd = 1; end
                    end
                    4, 7: begin
                        asa = 1; alu = 3'b110; ps = 2'b01;
                        pce = (cls == 4) ? z : !z;
                    end
                    5: begin ps = 2'b10; pce = 1; end
                    6: begin
                        if (s == 1) begin asa = 1; asb = 2'b10; alu = 3'b010; end
                        else rw = 1;
                    end
                    default: ;
                endcase
            end
        end
        if (rst) begin pce = 0; irw = 0; rw = 0; mwr = 0; ill = 0; end
        return {irw, mrd, mwr, asa, m2r, io, rw, rd, pce, ps, asb, alu, ill};
    endfunction

    function automatic int next_k(input int f, input int k, input int cls,
                                  input logic [5:0] o, input logic mr);
        int s;
        if (k < f) return mr ? k + 1 : k;
        s = k - f;
        if (s == 0) return (op_class(o) != 0) ? k + 1 : 0;
        if ((cls == 1 || cls == 2) && s == 2 && !mr) return k;
        return (s == inst_len(cls)) ? 0 : k + 1;
    endfunction

    int mk0 = 0, mcls0 = 0, mk1 = 0, mcls1 = 0;

    always @(posedge clk or posedge reset0) begin
        if (reset0) mk0 <= 0;
        else begin
            mk0 <= next_k(4, mk0, mcls0, op, mem_ready);
            if (mk0 == 4) mcls0 <= op_class(op);
        end
    end

    always @(posedge clk or posedge reset1) begin
        if (reset1) mk1 <= 0;
        else begin
            mk1 <= next_k(1, mk1, mcls1, op, mem_ready);
            if (mk1 == 1) mcls1 <= op_class(op);
        end
    end

    always @(negedge clk) begin
        chk("model_f4", v0, model_out(4, mk0, mcls0, reset0, op, funct, zero, mem_ready));
        chk("model_f1", v1, model_out(1, mk1, mcls1, reset1, op, funct, zero, mem_ready));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction on the F=4 instance, stalling MEMRD/MEMWR `stalls` times.
    task automatic run_instr(input int stalls, output int ncyc, output int nrd,
                             output int nwb);
        int left;
        left = stalls; ncyc = 0; nrd = 0; nwb = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0 && irwrite0 == 4'b0001) begin
                ncyc = c;
                break;
            end
            mem_ready = (iord0 && left > 0) ? 1'b0 : 1'b1;
            if (!mem_ready) left--;
            #1;
            if (memread0 && iord0) nrd++;
            if (memtoreg0 && regwrite0) nwb++;
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] op_tab [8] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08, 6'h05, 6'h3F};
    logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        int ncyc, nrd, nwb, idx;
        reset0 = 1; reset1 = 1; op = 6'h00; funct = 6'h20; zero = 0; mem_ready = 1;
        repeat (2) tick();
        chk("rst_pcen", 20'(pcen0), 20'h0);
        chk("rst_irwrite", 20'(irwrite0), 20'h0);
        chk("rst_memread", 20'(memread0), 20'h1);
        chk("rst_alusrcb", 20'(alusrcb0), 20'h1);

        // R-type add
        reset0 = 0; reset1 = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("fetch_irwrite", 20'(irwrite0), 20'(1 << i));
            chk("fetch_pcen", 20'(pcen0), 20'h1);
            tick();
        end
        chk("dec_alusrcb", 20'(alusrcb0), 20'h3);
        tick();
        chk("rtype_alu", 20'(aluctrl0), 20'h2);
        tick();
        chk("rtypewb_regwrite", 20'(regwrite0), 20'h1);
        chk("rtypewb_regdst", 20'(regdst0), 20'h1);
        tick();

        // lw with 3 stall cycles in MEMRD
        op = 6'h23;
        #1;
        run_instr(3, ncyc, nrd, nwb);
        chk("lw_cycles", 20'(ncyc), 20'd11);
        chk("lw_memrd_cycles", 20'(nrd), 20'd4);
        chk("lw_memwb", 20'(nwb), 20'd1);

        // beq taken then not taken
        for (int t = 0; t < 2; t++) begin
            op = 6'h04; zero = (t == 0);
            #1;
            repeat (5) tick();
            chk("beq_pcen", 20'(pcen0), (t == 0) ? 20'h1 : 20'h0);
            chk("beq_pcsrc", 20'(pcsrc0), 20'h1);
            tick();
            chk("beq_return", 20'(irwrite0), 20'h1);
        end

        // undefined op
        op = 6'h3F;
        #1;
        repeat (4) tick();
        chk("illegal_pulse", 20'(illegal0), 20'h1);
        tick();
        chk("illegal_clear", 20'(illegal0), 20'h0);
        chk("illegal_refetch", 20'(irwrite0), 20'h1);

        // op 0x05
        op = 6'h05; zero = 0;
        #1;
        repeat (4) tick();
`ifdef MC_BNE_EN
        chk("bne_legal", 20'(illegal0), 20'h0);
        tick();
        chk("bne_pcen", 20'(pcen0), 20'h1);
        tick();
`else
        chk("bne_illegal", 20'(illegal0), 20'h1);
        tick();
`endif
        chk("bne_refetch", 20'(irwrite0), 20'h1);

        // reset during MEMWR
        op = 6'h2B;
        #1;
        repeat (6) tick();
        mem_ready = 0;
        #1;
        chk("sw_memwrite", 20'(memwrite0), 20'h1);
        #1;
        reset0 = 1; reset1 = 1;
        #1;
        chk("rst_memwrite_async", 20'(memwrite0), 20'h0);
        chk("rst_irwrite_f1", 20'(irwrite1), 20'h0);
        tick();
        reset0 = 0; reset1 = 0; mem_ready = 1;
        #1;
        chk("f1_irwrite", 20'(irwrite1), 20'h1);
        chk("f4_beat0", 20'(irwrite0), 20'h1);
        tick();
        chk("f1_decode", 20'(alusrcb1), 20'h3);
        chk("f1_decode_irw", 20'(irwrite1), 20'h0);
        chk("f4_beat1", 20'(irwrite0), 20'h2);

        // randomized run on the F=4 instance; op/funct only change during fetch
        reset1 = 1;
        for (int c = 0; c < 3000; c++) begin
            if (mk0 < 4) begin
                idx = int'($urandom % 9);
                op = (idx == 8) ? 6'($urandom) : op_tab[idx];
                idx = int'($urandom % 6);
                funct = (idx == 5) ? 6'($urandom) : fn_tab[idx];
            end
            zero = 1'($urandom % 2);
            mem_ready = ($urandom % 4) != 0;
            reset0 = ($urandom % 100) == 0;
            tick();
        end
        reset0 = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
